multi_cycle_control_unit: RTL

- Multi-cycle CPU controller: sequences one instruction through IF/ID/EXE/MEM/WB states.
- Generates the per-state datapath controls, including the PC write enable (PCWre) and the next-PC select that drive the program counter.
- Exports the current state so the PC, instruction register and register file can qualify their writes.
- Sits between the instruction register (opcode) / ALU (zero flag) and the PC, register file, ALU and data memory.

---
 rtl/multi_cycle_control_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EXE/MEM/WB sequencer and datapath control decode for a multi-cycle CPU
module multi_cycle_control_unit #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic [STW-1:0] State,
    output logic           PCWre,
    output logic [1:0]     PCSrc,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           RegWre,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           ExtSel,
    output logic           mRD,
    output logic           mWR,
    output logic           DBDataSrc
);
    localparam logic [STW-1:0] S_IF   = STW'(3'b000);
    localparam logic [STW-1:0] S_ID   = STW'(3'b001);
    localparam logic [STW-1:0] S_EXE  = STW'(3'b010);
    localparam logic [STW-1:0] S_MEM  = STW'(3'b011);
    localparam logic [STW-1:0] S_WBR  = STW'(3'b100);
    localparam logic [STW-1:0] S_WBL  = STW'(3'b101);
    localparam logic [STW-1:0] S_HALT = STW'(3'b111);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR    = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    logic [STW-1:0] state_q, state_d, state_n;
    logic op_add, op_sub, op_addiu, op_and, op_ori, op_slt, op_sw, op_lw;
    logic op_beq, op_bne, op_j, op_jr, op_jal, op_halt, op_r, op_undef;
    logic in_id, in_exe, in_mem, in_wbr, in_wbl, alu_on, pc_wr;

    assign op_add   = opcode == OP_ADD;
    assign op_sub   = opcode == OP_SUB;
    assign op_addiu = opcode == OP_ADDIU;
    assign op_and   = opcode == OP_AND;
    assign op_ori   = opcode == OP_ORI;
    assign op_slt   = opcode == OP_SLT;
    assign op_sw    = opcode == OP_SW;
    assign op_lw    = opcode == OP_LW;
    assign op_beq   = opcode == OP_BEQ;
    assign op_bne   = opcode == OP_BNE;
    assign op_j     = opcode == OP_J;
    assign op_jr    = opcode == OP_JR;
    assign op_jal   = opcode == OP_JAL;
    assign op_halt  = opcode == OP_HALT;
    assign op_r     = op_add | op_sub | op_and | op_slt;
    assign op_undef = !(op_r | op_addiu | op_ori | op_sw | op_lw | op_beq | op_bne |
                        op_j | op_jr | op_jal | op_halt);

    assign in_id  = state_q == S_ID;
    assign in_exe = state_q == S_EXE;
    assign in_mem = state_q == S_MEM;
    assign in_wbr = state_q == S_WBR;
    assign in_wbl = state_q == S_WBL;
    assign alu_on = in_exe | in_mem | in_wbr | in_wbl;

    // State register; the only flop in the controller
    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    // Next-state sequencing; reset overrides everything and returns to fetch
    always_comb begin
        state_n = S_IF;
        case (state_q)
            S_IF:   state_n = S_ID;
            S_ID:   state_n = (op_j | op_jr | op_jal | op_undef) ? S_IF : op_halt ? S_HALT : S_EXE;
            S_EXE:  state_n = (op_beq | op_bne) ? S_IF : (op_lw | op_sw) ? S_MEM : S_WBR;
            S_MEM:  state_n = op_lw ? S_WBL : S_IF;
            S_HALT: state_n = S_HALT;
            default: state_n = S_IF;
        endcase
        state_d = RST ? S_IF : state_n;
    end

    // Datapath controls; every write strobe is suppressed while RST is high
    always_comb begin
        pc_wr     = !RST && state_n == S_IF && (in_id | in_exe | in_mem | in_wbr | in_wbl);
        PCWre     = pc_wr;
        PCSrc     = !pc_wr ? 2'b00 :
                    (in_id && (op_j | op_jal)) ? 2'b11 :
                    (in_id && op_jr) ? 2'b10 :
                    (in_exe && ((op_beq && zero) || (op_bne && !zero))) ? 2'b01 : 2'b00;
        IRWre     = !RST && state_q == S_IF;
        InsMemRW  = !RST && state_q == S_IF;
        RegWre    = !RST && (in_wbr || in_wbl || (in_id && op_jal));
        RegDst    = in_wbr ? (op_r ? 2'b10 : 2'b01) : in_wbl ? 2'b01 : 2'b00;
        WrRegDSrc = in_wbr | in_wbl;
        DBDataSrc = in_wbl;
        ALUSrcA   = 1'b0;
        ALUSrcB   = alu_on && (op_addiu | op_ori | op_lw | op_sw);
        ExtSel    = alu_on && !op_ori;
        ALUOp     = !alu_on ? 3'b000 :
                    (op_sub | op_beq | op_bne) ? 3'b001 :
                    op_and ? 3'b100 :
                    op_ori ? 3'b101 :
                    op_slt ? 3'b110 : 3'b000;
        mRD       = !RST && in_mem && op_lw;
        mWR       = !RST && in_mem && op_sw;
        State     = state_q;
    end
endmodule
